// File: rtl/mux_arbiter.sv
// Two-source round-robin arbiter driving a shared 2:1 mux into one registered output stage.
// Define MUX_ARB_FIXED_PRIO_EN to give source A fixed priority instead of round-robin.
//
// state   | meaning
// IDLE    | no grant; arbitrate among valid sources
// GRANT_A | A owns the mux for up to BURST_LEN beats
// GRANT_B | B owns the mux for up to BURST_LEN beats
module mux_arbiter #(
   parameter int BUS_WIDTH = 4,
   parameter int BURST_LEN = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BUS_WIDTH-1:0] a_data,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [BUS_WIDTH-1:0] b_data,
   input  logic                 b_valid,
   output logic                 b_ready,
   output logic [BUS_WIDTH-1:0] q,
   output logic                 q_valid,
   input  logic                 q_ready,
   output logic                 switch,
   output logic                 busy
);

   localparam int CW = $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 last_a_q, last_a_d;
   logic                 switch_q, switch_d;
   logic [BUS_WIDTH-1:0] q_q, q_d;
   logic                 q_valid_q, q_valid_d;

   logic can_load;
   logic a_xfer;
   logic b_xfer;
   logic burst_done;

   assign can_load   = !q_valid_q || q_ready;
   assign a_ready    = (state_q == GRANT_A) && can_load;
   assign b_ready    = (state_q == GRANT_B) && can_load;
   assign a_xfer     = a_valid && a_ready;
   assign b_xfer     = b_valid && b_ready;
   assign burst_done = (count_q == LAST_BEAT);

   assign q       = q_q;
   assign q_valid = q_valid_q;
   assign switch  = switch_q;
   assign busy    = (state_q != IDLE);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      last_a_d = last_a_q;
      case (state_q)
         IDLE: begin
`ifdef MUX_ARB_FIXED_PRIO_EN
            if (a_valid)      state_d = GRANT_A;
            else if (b_valid) state_d = GRANT_B;
`else
            if (a_valid && b_valid) state_d = last_a_q ? GRANT_B : GRANT_A;
            else if (a_valid)       state_d = GRANT_A;
            else if (b_valid)       state_d = GRANT_B;
`endif
         end
         GRANT_A: begin
            if (!a_valid || (a_xfer && burst_done)) begin
               last_a_d = 1'b1;
               count_d  = '0;
`ifdef MUX_ARB_FIXED_PRIO_EN
               // A keeps the bus on contention even at its own burst limit
               state_d  = b_valid ? (a_valid ? GRANT_A : GRANT_B) : IDLE;
`else
               state_d  = b_valid ? GRANT_B : IDLE;
`endif
            end else if (a_xfer) begin
               count_d = count_q + CW'(1);
            end
         end
         GRANT_B: begin
            if (!b_valid || (b_xfer && burst_done)) begin
               last_a_d = 1'b0;
               count_d  = '0;
`ifdef MUX_ARB_FIXED_PRIO_EN
               state_d  = a_valid ? GRANT_A : (b_valid ? GRANT_B : IDLE);
`else
               state_d  = a_valid ? GRANT_A : IDLE;
`endif
            end else if (b_xfer) begin
               count_d = count_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   always_comb begin
      switch_d = switch_q;
      case (state_d)
         GRANT_A: switch_d = 1'b1;
         GRANT_B: switch_d = 1'b0;
         default: switch_d = switch_q;
      endcase
   end

   always_comb begin
      q_d       = q_q;
      q_valid_d = q_valid_q;
      if (a_xfer) begin
         q_d       = a_data;
         q_valid_d = 1'b1;
      end else if (b_xfer) begin
         q_d       = b_data;
         q_valid_d = 1'b1;
      end else if (q_ready) begin
         q_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         count_q   <= '0;
         last_a_q  <= 1'b0;
         switch_q  <= 1'b0;
         q_q       <= '0;
         q_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         last_a_q  <= last_a_d;
         switch_q  <= switch_d;
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
      end
   end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter; build with MUX_ARB_FIXED_PRIO_EN to exercise fixed priority.
module tb_mux_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] a_data = '0;
   logic       a_valid = 1'b0;
   logic       a_ready;
   logic [3:0] b_data = '0;
   logic       b_valid = 1'b0;
   logic       b_ready;
   logic [3:0] q;
   logic       q_valid;
   logic       q_ready = 1'b1;
   logic       switch;
   logic       busy;

   int checks = 0;
   int errors = 0;

   mux_arbiter #(.BUS_WIDTH(4), .BURST_LEN(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .q(q), .q_valid(q_valid), .q_ready(q_ready),
      .switch(switch), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; q_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      a_valid = 1'b1; b_valid = 1'b1; a_data = 4'h7; b_data = 4'h9; q_ready = 1'b1;
      tick(); tick();
      checks++; if (q !== 4'h0)    begin errors++; $display("FAIL rst_q: got %h want 0", q); end
      checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL rst_q_valid: got %b want 0", q_valid); end
      checks++; if (switch !== 1'b0)  begin errors++; $display("FAIL rst_switch: got %b want 0", switch); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0)
         begin errors++; $display("FAIL rst_ready: got a=%b b=%b want 0 0", a_ready, b_ready); end
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_a;
      do_reset();
      a_valid = 1'b1; a_data = 4'd1;
      #1;
      checks++; if (busy !== 1'b0 || a_ready !== 1'b0)
         begin errors++; $display("FAIL single_c0: got busy=%b a_ready=%b want 0 0", busy, a_ready); end
      tick();
      checks++; if (busy !== 1'b1 || switch !== 1'b1 || a_ready !== 1'b1 || q_valid !== 1'b0)
         begin errors++; $display("FAIL single_c1: got busy=%b sw=%b a_ready=%b qv=%b want 1 1 1 0",
                                  busy, switch, a_ready, q_valid); end
      for (int k = 1; k <= 4; k++) begin
         tick();
         a_data = 4'(k + 1);
         checks++; if (q !== 4'(k) || q_valid !== 1'b1)
            begin errors++; $display("FAIL single_q beat %0d: got q=%h qv=%b want %h 1", k, q, q_valid, 4'(k)); end
         checks++; if (switch !== 1'b1)
            begin errors++; $display("FAIL single_switch beat %0d: got %b want 1", k, switch); end
         checks++; if (busy !== (k < 4))
            begin errors++; $display("FAIL single_busy beat %0d: got %b want %b", k, busy, (k < 4)); end
      end
      tick();
      checks++; if (busy !== 1'b1 || q_valid !== 1'b0)
         begin errors++; $display("FAIL single_regrant: got busy=%b qv=%b want 1 0", busy, q_valid); end
      tick();
      checks++; if (q !== 4'd5 || q_valid !== 1'b1)
         begin errors++; $display("FAIL single_beat5: got q=%h qv=%b want 5 1", q, q_valid); end
      a_valid = 1'b0;
      tick();
      checks++; if (busy !== 1'b0 || q_valid !== 1'b0 || switch !== 1'b1)
         begin errors++; $display("FAIL single_idle_hold: got busy=%b qv=%b sw=%b want 0 0 1",
                                  busy, q_valid, switch); end
   endtask

   task automatic test_alternate;
      int a_cnt, b_cnt, d, g, p;
      logic acc_a, acc_b, exp_sw;
      logic [3:0] exp_q;
      do_reset();
      a_cnt = 0; b_cnt = 0; acc_a = 1'b0; acc_b = 1'b0;
      a_valid = 1'b1; b_valid = 1'b1; a_data = 4'd0; b_data = 4'd8;
      for (int c = 1; c <= 13; c++) begin
         tick();
         if (acc_a) a_cnt++;
         if (acc_b) b_cnt++;
         a_data = 4'(a_cnt);
         b_data = 4'(8 + b_cnt);
         exp_sw = (((c - 1) / 4) % 2) == 0;
         if (c <= 12) begin
            checks++; if (switch !== exp_sw || busy !== 1'b1)
               begin errors++; $display("FAIL alt_switch c%0d: got sw=%b busy=%b want %b 1", c, switch, busy, exp_sw); end
         end
         if (c >= 2) begin
            d = c - 1; g = (d - 1) / 4; p = (d - 1) % 4;
            exp_q = (g % 2 == 0) ? 4'((g / 2) * 4 + p) : 4'(8 + (g / 2) * 4 + p);
            checks++; if (q !== exp_q || q_valid !== 1'b1)
               begin errors++; $display("FAIL alt_q c%0d: got q=%h qv=%b want %h 1", c, q, q_valid, exp_q); end
         end
         #1;
         acc_a = a_valid && a_ready;
         acc_b = b_valid && b_ready;
         if (c <= 12) begin
            checks++; if (a_ready !== exp_sw || b_ready !== !exp_sw)
               begin errors++; $display("FAIL alt_ready c%0d: got a=%b b=%b want %b %b",
                                        c, a_ready, b_ready, exp_sw, !exp_sw); end
         end
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_backpressure;
      do_reset();
      a_valid = 1'b1; a_data = 4'd1;
      tick();
      for (int s = 0; s < 3; s++) begin
         tick();
         if (s == 0) begin q_ready = 1'b0; a_data = 4'd2; end
         #1;
         checks++; if (q !== 4'd1 || q_valid !== 1'b1 || busy !== 1'b1 || switch !== 1'b1 || a_ready !== 1'b0)
            begin errors++; $display("FAIL bp_stall %0d: got q=%h qv=%b busy=%b sw=%b a_ready=%b want 1 1 1 1 0",
                                     s, q, q_valid, busy, switch, a_ready); end
      end
      tick();
      q_ready = 1'b1;
      #1;
      checks++; if (q !== 4'd1 || a_ready !== 1'b1)
         begin errors++; $display("FAIL bp_resume: got q=%h a_ready=%b want 1 1", q, a_ready); end
      tick();
      a_data = 4'd3;
      checks++; if (q !== 4'd2 || q_valid !== 1'b1)
         begin errors++; $display("FAIL bp_beat2: got q=%h qv=%b want 2 1", q, q_valid); end
      tick();
      a_data = 4'd4;
      checks++; if (q !== 4'd3 || busy !== 1'b1)
         begin errors++; $display("FAIL bp_beat3: got q=%h busy=%b want 3 1", q, busy); end
      tick();
      a_valid = 1'b0;
      checks++; if (q !== 4'd4 || busy !== 1'b0)
         begin errors++; $display("FAIL bp_beat4: got q=%h busy=%b want 4 0", q, busy); end
      tick();
      checks++; if (q_valid !== 1'b0)
         begin errors++; $display("FAIL bp_drain: got qv=%b want 0", q_valid); end
   endtask

   task automatic test_drop;
      do_reset();
      a_valid = 1'b1; b_valid = 1'b1; a_data = 4'd1; b_data = 4'd9;
      tick();
      checks++; if (switch !== 1'b1)
         begin errors++; $display("FAIL drop_first: got sw=%b want 1", switch); end
      tick();
      a_data = 4'd2;
      tick();
      checks++; if (q !== 4'd2)
         begin errors++; $display("FAIL drop_q2: got q=%h want 2", q); end
      a_valid = 1'b0;
      #1;
      checks++; if (b_ready !== 1'b0 || busy !== 1'b1)
         begin errors++; $display("FAIL drop_exit_cycle: got b_ready=%b busy=%b want 0 1", b_ready, busy); end
      tick();
      checks++; if (switch !== 1'b0 || busy !== 1'b1 || q_valid !== 1'b0)
         begin errors++; $display("FAIL drop_handover: got sw=%b busy=%b qv=%b want 0 1 0", switch, busy, q_valid); end
      #1;
      checks++; if (b_ready !== 1'b1)
         begin errors++; $display("FAIL drop_b_ready: got %b want 1", b_ready); end
      tick();
      checks++; if (q !== 4'd9 || q_valid !== 1'b1)
         begin errors++; $display("FAIL drop_bq: got q=%h qv=%b want 9 1", q, q_valid); end
      b_valid = 1'b0; a_valid = 1'b1; a_data = 4'd3;
      tick();
      checks++; if (switch !== 1'b1 || busy !== 1'b1)
         begin errors++; $display("FAIL drop_back_a: got sw=%b busy=%b want 1 1", switch, busy); end
      tick(); a_data = 4'd4;
      tick(); a_data = 4'd5;
      checks++; if (busy !== 1'b1)
         begin errors++; $display("FAIL drop_count_restart c8: got busy=%b want 1", busy); end
      tick(); a_data = 4'd6;
      checks++; if (busy !== 1'b1)
         begin errors++; $display("FAIL drop_count_restart c9: got busy=%b want 1", busy); end
      tick();
      checks++; if (busy !== 1'b0 || q !== 4'd6)
         begin errors++; $display("FAIL drop_burst_end: got busy=%b q=%h want 0 6", busy, q); end
      a_valid = 1'b0;
   endtask

   task automatic test_reset_mid;
      do_reset();
      a_valid = 1'b1; a_data = 4'd3;
      tick();
      tick();
      a_valid = 1'b0;
      tick();
      a_valid = 1'b1; a_data = 4'd5;
      tick();
      tick();
      checks++; if (q !== 4'd5 || q_valid !== 1'b1 || busy !== 1'b1 || switch !== 1'b1)
         begin errors++; $display("FAIL rmid_pre: got q=%h qv=%b busy=%b sw=%b want 5 1 1 1", q, q_valid, busy, switch); end
      rst_n = 1'b0;
      b_valid = 1'b1;
      #1;
      checks++; if (q_valid !== 1'b0 || busy !== 1'b0 || switch !== 1'b0 || q !== 4'd0 || a_ready !== 1'b0)
         begin errors++; $display("FAIL rmid_async: got qv=%b busy=%b sw=%b q=%h a_ready=%b want 0 0 0 0 0",
                                  q_valid, busy, switch, q, a_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (switch !== 1'b1 || busy !== 1'b1)
         begin errors++; $display("FAIL rmid_first_contention: got sw=%b busy=%b want 1 1", switch, busy); end
      #1;
      checks++; if (b_ready !== 1'b0)
         begin errors++; $display("FAIL rmid_b_ready: got %b want 0", b_ready); end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_fixed_prio;
      do_reset();
      a_valid = 1'b1; b_valid = 1'b1; a_data = 4'd1; b_data = 4'd9;
      for (int c = 1; c <= 12; c++) begin
         tick();
         checks++; if (switch !== 1'b1 || busy !== 1'b1)
            begin errors++; $display("FAIL fixed_switch c%0d: got sw=%b busy=%b want 1 1", c, switch, busy); end
         #1;
         checks++; if (b_ready !== 1'b0 || a_ready !== 1'b1)
            begin errors++; $display("FAIL fixed_ready c%0d: got a=%b b=%b want 1 0", c, a_ready, b_ready); end
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_a();
`ifdef MUX_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`else
      test_alternate();
`endif
      test_backpressure();
      test_drop();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
